regfile_param: RTL and testbench
================================

# regfile_param

Parametrised multi-port register file, successor to the fixed 8×8 single-read-port register file. One write port with arithmetic write modes, two independent combinational read ports with optional write-through bypass, and a sequential clear-sweep engine that zeroes the array one entry per cycle. It sits in the datapath experiments as the general-purpose register store feeding ALU operands A and B.

## Interface
- WIDTH, 8, data width of each register
- DEPTH, 8, number of registers (2..2^ADDR_W)
- ADDR_W, 3, width of select fields; DEPTH ≤ 2^ADDR_W
- BYPASS, 1, 1 = write-through forwarding on read ports, 0 = reads show stored value only

- clk  in  1  clock, all state updates on rising edge
- clr  in  1  asynchronous active-high reset
- wen  in  1  write enable
- wop  in  2  write op: 00 load d, 01 increment, 10 decrement, 11 add d
- wsel  in  ADDR_W  write register select
- d  in  WIDTH  write data
- rsel_a  in  ADDR_W  read port A select
- rsel_b  in  ADDR_W  read port B select
- qa  out  WIDTH  read port A data
- qb  out  WIDTH  read port B data
- sweep_start  in  1  request clear sweep of whole array
- busy  out  1  sweep in progress

## Operation
- Write result res = d (00), r[wsel]+1 (01), r[wsel]−1 (10), r[wsel]+d (11); all modulo 2^WIDTH, carry/borrow discarded (0xFF+1 → 0x00, 0x00−1 → 0xFF at WIDTH=8).
- Write commits at rising edge when wen=1, busy=0, wsel<DEPTH. wsel≥DEPTH: no write, no side effects.
- Reads combinational: q = r[rsel] for rsel<DEPTH; rsel≥DEPTH → 0.
- Bypass (BYPASS=1): if write would commit this cycle and rsel==wsel, port shows res instead of r[rsel]. Both ports forward independently. BYPASS=0: stored value only.
- Sweep FSM, states IDLE and SWEEP, pointer ptr (ADDR_W bits).
  - IDLE: sweep_start=1 → SWEEP, ptr=0.
  - SWEEP: each edge clears r[ptr], ptr++; after clearing r[DEPTH−1] → IDLE.
  - busy = (state==SWEEP).
- During SWEEP: all writes dropped (no bypass), sweep_start ignored, reads continue and show current stored values.
- sweep_start and wen in same IDLE cycle: write commits at that edge, entry later cleared by sweep.

## Timing
- Reset (clr=1, async): all registers 0, state IDLE, ptr 0, busy 0; qa/qb = 0 immediately. Reset mid-sweep aborts sweep; no resumption after release.
- Write latency: stored value visible one edge after commit; with BYPASS=1 visible in the same cycle.
- Sweep: start sampled at edge k → busy=1 after k; r[i] cleared at edge k+1+i; busy falls after edge k+DEPTH; exactly DEPTH busy cycles. First write accepted at edge k+DEPTH+1.
- Write to register whose clear is still pending: write dropped anyway (busy=1).
- No combinational path from sweep_start to qa/qb/busy.

## Test plan
- Reset/load: clr pulse, check qa=qb=0; load 0x5A to r3, 0xA5 to r7; rsel_a=3, rsel_b=7 → qa=0x5A, qb=0xA5 next cycle.
- Arithmetic wrap: r2=0xFF, wop=01 → 0x00; wop=10 → 0xFF; r4=0x80, wop=11 d=0x90 → 0x10.
- Bypass: BYPASS=1, r1=0x10, wen wop=01 wsel=1, rsel_a=rsel_b=1 → qa=qb=0x11 same cycle; BYPASS=0 build → qa=0x10 same cycle, 0x11 after edge.
- Sweep: fill r0..r7 with 0x11..0x88, pulse sweep_start → busy high exactly 8 cycles, r0 reads 0 after first busy edge, r7 after eighth; wen=1 d=0xEE during busy → no register changes; writes accepted after busy falls.
- Out-of-range: DEPTH=6 ADDR_W=3, write wsel=6 d=0x33 → no change anywhere; rsel_a=7 → qa=0.
- Reset mid-sweep: assert clr at 3rd busy cycle → busy=0, all registers 0 immediately, FSM stays IDLE after release.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: one arithmetic write port, two combinational read
// ports with optional write-through, and a one-entry-per-cycle clear sweep.
module regfile_param #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wen,
    input  logic [1:0]        wop,
    input  logic [ADDR_W-1:0] wsel,
    input  logic [WIDTH-1:0]  d,
    input  logic [ADDR_W-1:0] rsel_a,
    input  logic [ADDR_W-1:0] rsel_b,
    output logic [WIDTH-1:0]  qa,
    output logic [WIDTH-1:0]  qb,
    input  logic              sweep_start,
    output logic              busy,
    output logic              dbg_state,
    output logic [ADDR_W-1:0] dbg_ptr
);

    typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

    localparam logic [ADDR_W:0]   DEPTH_W = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_ptr, w_ptr_next;
    logic [WIDTH-1:0]  r_regs [DEPTH];

    logic              w_wr_in_range;
    logic              w_commit;
    logic [WIDTH-1:0]  w_cur;
    logic [WIDTH-1:0]  w_res;
    logic [WIDTH-1:0]  w_rd_a, w_rd_b;

    // Handshake-free port: a write is accepted exactly when wen is high, the
    // sweep is idle and wsel addresses a real entry; otherwise it vanishes.
    assign w_wr_in_range = ({1'b0, wsel} < DEPTH_W);
    assign w_commit      = wen && (r_state == S_IDLE) && w_wr_in_range;
    assign busy          = (r_state == S_SWEEP);
    assign dbg_state     = r_state;
    assign dbg_ptr       = r_ptr;

    always_comb begin
        w_cur = '0;
        if (w_wr_in_range) w_cur = r_regs[wsel];
        case (wop)
            2'b00:   w_res = d;
            2'b01:   w_res = w_cur + WIDTH'(1);
            2'b10:   w_res = w_cur - WIDTH'(1);
            default: w_res = w_cur + d;
        endcase
    end

    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        if ({1'b0, rsel_a} < DEPTH_W) w_rd_a = r_regs[rsel_a];
        if ({1'b0, rsel_b} < DEPTH_W) w_rd_b = r_regs[rsel_b];
        qa = w_rd_a;
        qb = w_rd_b;
        // w_commit is already low during a sweep, so forwarding stops there too
        if ((BYPASS != 0) && w_commit && (rsel_a == wsel)) qa = w_res;
        if ((BYPASS != 0) && w_commit && (rsel_b == wsel)) qb = w_res;
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (sweep_start) begin
                    w_state_next = S_SWEEP;
                    w_ptr_next   = '0;
                end
            end
            default: begin
                if (r_ptr == LAST) begin
                    w_state_next = S_IDLE;
                    w_ptr_next   = '0;
                end else begin
                    w_ptr_next   = r_ptr + ADDR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (r_state == S_SWEEP) begin
            r_regs[r_ptr] <= '0;
        end else if (w_commit) begin
            r_regs[wsel] <= w_res;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three builds (default, no bypass, DEPTH=6) share one
// stimulus stream and are checked against an array-based reference model.
module tb_regfile_param;

    logic       clk;
    logic       clr;
    logic       wen;
    logic [1:0] wop;
    logic [2:0] wsel;
    logic [7:0] d;
    logic [2:0] rsel_a, rsel_b;
    logic       sweep_start;

    logic [7:0] qa_o   [3];
    logic [7:0] qb_o   [3];
    logic       busy_o [3];
    logic       dbg_st [3];
    logic [2:0] dbg_p  [3];

    int total = 0;
    int bad   = 0;

    // reference model: per-build contents and sweep progress (-1 = not sweeping)
    logic [7:0] mem [3][8];
    int         sweep_i [3];
    int         depth [3] = '{8, 8, 6};
    bit         byp   [3] = '{1'b1, 1'b0, 1'b1};

    regfile_param #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .BYPASS(1)) u_def (
        .clk(clk), .clr(clr), .wen(wen), .wop(wop), .wsel(wsel), .d(d),
        .rsel_a(rsel_a), .rsel_b(rsel_b), .qa(qa_o[0]), .qb(qb_o[0]),
        .sweep_start(sweep_start), .busy(busy_o[0]),
        .dbg_state(dbg_st[0]), .dbg_ptr(dbg_p[0]));

    regfile_param #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .BYPASS(0)) u_nobyp (
        .clk(clk), .clr(clr), .wen(wen), .wop(wop), .wsel(wsel), .d(d),
        .rsel_a(rsel_a), .rsel_b(rsel_b), .qa(qa_o[1]), .qb(qb_o[1]),
        .sweep_start(sweep_start), .busy(busy_o[1]),
        .dbg_state(dbg_st[1]), .dbg_ptr(dbg_p[1]));

    regfile_param #(.WIDTH(8), .DEPTH(6), .ADDR_W(3), .BYPASS(1)) u_d6 (
        .clk(clk), .clr(clr), .wen(wen), .wop(wop), .wsel(wsel), .d(d),
        .rsel_a(rsel_a), .rsel_b(rsel_b), .qa(qa_o[2]), .qb(qb_o[2]),
        .sweep_start(sweep_start), .busy(busy_o[2]),
        .dbg_state(dbg_st[2]), .dbg_ptr(dbg_p[2]));

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    function automatic bit m_commit(int k);
        return wen && (sweep_i[k] < 0) && (int'(wsel) < depth[k]);
    endfunction

    function automatic logic [7:0] m_res(int k);
        logic [7:0] cur;
        cur = (int'(wsel) < depth[k]) ? mem[k][wsel] : 8'h00;
        case (wop)
            2'd0:    return d;
            2'd1:    return cur + 8'd1;
            2'd2:    return cur - 8'd1;
            default: return cur + d;
        endcase
    endfunction

    function automatic logic [7:0] m_read(int k, logic [2:0] rs);
        logic [7:0] v;
        v = (int'(rs) < depth[k]) ? mem[k][rs] : 8'h00;
        if (byp[k] && m_commit(k) && rs == wsel) v = m_res(k);
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) mem[k][i] = 8'h00;
            sweep_i[k] = -1;
        end
    endtask

    // advance the model across one rising edge using the inputs now applied
    task automatic model_edge();
        if (clr) return;
        for (int k = 0; k < 3; k++) begin
            if (sweep_i[k] >= 0) begin
                mem[k][sweep_i[k]] = 8'h00;
                sweep_i[k]++;
                if (sweep_i[k] == depth[k]) sweep_i[k] = -1;
            end else begin
                if (m_commit(k)) mem[k][wsel] = m_res(k);
                if (sweep_start) sweep_i[k] = 0;
            end
        end
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s qa[%0d] rsel=%0d", tag, k, rsel_a), qa_o[k], m_read(k, rsel_a));
            chk($sformatf("%s qb[%0d] rsel=%0d", tag, k, rsel_b), qb_o[k], m_read(k, rsel_b));
            chk($sformatf("%s busy[%0d]", tag, k), {7'd0, busy_o[k]}, {7'd0, sweep_i[k] >= 0});
        end
    endtask

    // sweep every read address without crossing a clock edge
    task automatic read_all(string tag);
        for (int i = 0; i < 8; i++) begin
            rsel_a = 3'(i);
            rsel_b = 3'(7 - i);
            #1;
            check_all(tag);
        end
    endtask

    task automatic tick(string tag);
        @(negedge clk);
        check_all(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic write(logic [2:0] sel, logic [1:0] op, logic [7:0] data);
        wen = 1'b1; wsel = sel; wop = op; d = data;
        tick("write");
        wen = 1'b0;
    endtask

    initial begin
        clr = 1'b1; wen = 1'b0; wop = 2'd0; wsel = 3'd0; d = 8'h00;
        rsel_a = 3'd0; rsel_b = 3'd0; sweep_start = 1'b0;
        model_reset();
        #3;
        read_all("reset");
        @(posedge clk); #1;
        clr = 1'b0;

        // reset/load
        write(3'd3, 2'd0, 8'h5A);
        write(3'd7, 2'd0, 8'hA5);
        rsel_a = 3'd3; rsel_b = 3'd7;
        tick("load_read");

        // arithmetic wrap
        write(3'd2, 2'd0, 8'hFF);
        rsel_a = 3'd2; rsel_b = 3'd4;
        write(3'd2, 2'd1, 8'h00);
        tick("inc_wrap");
        write(3'd2, 2'd2, 8'h00);
        tick("dec_wrap");
        write(3'd4, 2'd0, 8'h80);
        write(3'd4, 2'd3, 8'h90);
        tick("add_wrap");

        // bypass vs stored-only reads in the same cycle
        write(3'd1, 2'd0, 8'h10);
        rsel_a = 3'd1; rsel_b = 3'd1;
        write(3'd1, 2'd1, 8'h00);
        tick("bypass_after");

        // sweep with writes attempted throughout
        for (int i = 0; i < 8; i++) write(3'(i), 2'd0, 8'(8'h11 * (i + 1)));
        read_all("filled");
        sweep_start = 1'b1;
        tick("sweep_start");
        sweep_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wen = 1'b1; wop = 2'd0; d = 8'hEE; wsel = 3'(i);
            rsel_a = 3'(i); rsel_b = 3'(i - 1);
            sweep_start = i[0];
            tick("sweeping");
        end
        wen = 1'b0; sweep_start = 1'b0;
        read_all("after_sweep");
        write(3'd5, 2'd0, 8'h77);
        read_all("write_after_sweep");

        // out-of-range write and read
        write(3'd6, 2'd0, 8'h33);
        read_all("oor");

        // reset in the middle of a sweep
        sweep_start = 1'b1;
        tick("sweep2_start");
        sweep_start = 1'b0;
        tick("sweep2_b1");
        tick("sweep2_b2");
        #2;
        clr = 1'b1;
        model_reset();
        #1;
        read_all("mid_reset");
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 0; i < 4; i++) tick("post_reset_idle");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            wen         = 1'($urandom_range(0, 1));
            wop         = 2'($urandom_range(0, 3));
            wsel        = 3'($urandom_range(0, 7));
            d           = 8'($urandom_range(0, 255));
            rsel_a      = ($urandom_range(0, 3) == 0) ? wsel : 3'($urandom_range(0, 7));
            rsel_b      = ($urandom_range(0, 3) == 0) ? wsel : 3'($urandom_range(0, 7));
            sweep_start = ($urandom_range(0, 29) == 0);
            tick("random");
        end
        wen = 1'b0; sweep_start = 1'b0;
        for (int i = 0; i < 10; i++) tick("drain");
        read_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
